// File: rtl/rf_seq_pkg.sv
// rf_seq_pkg
// Shared definitions for the register-file command sequencer:
//   - default data/address widths
//   - opcode encodings (LOADI, MOV, ADD, SUB)
//   - sequencer state enum
package rf_seq_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 4;

    localparam logic [1:0] OP_LOADI = 2'b00;
    localparam logic [1:0] OP_MOV   = 2'b01;
    localparam logic [1:0] OP_ADD   = 2'b10;
    localparam logic [1:0] OP_SUB   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_EXEC  = 3'd2,
        S_WRITE = 3'd3,
        S_FIN   = 3'd4
    } state_t;

endpackage

// File: rtl/rf_seq_alu.sv
// rf_seq_alu
// Combinational ALU for the sequencer.
// Ports:
//   op     in  2       opcode (rf_seq_pkg OP_*)
//   a, b   in  DATA_W  operands A and B
//   result out DATA_W  MOV: b, ADD: a+b, SUB: a-b (mod 2^DATA_W); LOADI: 0
//   carry  out 1       ADD: carry out, SUB: borrow (a<b), otherwise 0
module rf_seq_alu
    import rf_seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              carry
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    // One extra bit: the top bit is the carry for ADD and wraps to 1 on borrow for SUB.
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        result = '0;
        carry  = 1'b0;
        case (op)
            OP_MOV: result = b;
            OP_ADD: {carry, result} = sum;
            OP_SUB: {carry, result} = diff;
            default: ;
        endcase
    end

endmodule

// File: rtl/rf_sequencer.sv
// rf_sequencer
// Multi-cycle command sequencer in front of the 8-bit register file. Accepts one
// command (LOADI/MOV/ADD/SUB), drives the read addresses, captures the ALU result
// and issues a single-cycle write-back.
//
// Optional feature: define RF_SEQ_FLAGS_EN to add the CARRY/ZERO status flags.
//
// Ports:
//   CLOCK_50  in   system clock, rising edge
//   RESET     in   asynchronous, active-high reset
//   START     in   command strobe (only looked at in IDLE)
//   OP        in   opcode, RX/RY register operands, IMM immediate for LOADI
//   BUSY      out  high outside IDLE
//   DONE      out  one-cycle completion pulse
//   RESULT    out  last written-back value
//   RF_REGA/B out  read addresses, RF_DATAA/B in read data
//   RF_REGW, RF_DATAW, RF_WRITE  out  write port
//   CARRY, ZERO  out  status flags (RF_SEQ_FLAGS_EN only)
//
// state   | meaning
// --------+---------------------------------------------
// S_IDLE  | waiting for START, read addresses hold
// S_READ  | read addresses settle / registered RF read
// S_EXEC  | sample read data, capture ALU result
// S_WRITE | RF_WRITE high, RESULT/flags update
// S_FIN   | DONE pulse, back to IDLE
module rf_sequencer
    import rf_seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              CLOCK_50,
    input  logic              RESET,
    input  logic              START,
    input  logic [1:0]        OP,
    input  logic [ADDR_W-1:0] RX,
    input  logic [ADDR_W-1:0] RY,
    input  logic [DATA_W-1:0] IMM,
    output logic              BUSY,
    output logic              DONE,
    output logic [DATA_W-1:0] RESULT,
    output logic [ADDR_W-1:0] RF_REGA,
    output logic [ADDR_W-1:0] RF_REGB,
    output logic [ADDR_W-1:0] RF_REGW,
    output logic [DATA_W-1:0] RF_DATAW,
    output logic              RF_WRITE,
    input  logic [DATA_W-1:0] RF_DATAA,
    input  logic [DATA_W-1:0] RF_DATAB
`ifdef RF_SEQ_FLAGS_EN
    ,
    output logic              CARRY,
    output logic              ZERO
`endif
);

    state_t state, state_nxt;

    logic [1:0]        op_q;
    logic [ADDR_W-1:0] rx_q;
    logic [DATA_W-1:0] imm_q;
    logic [DATA_W-1:0] alu_q;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] wr_data;
`ifdef RF_SEQ_FLAGS_EN
    logic              alu_carry;
    logic              carry_q;
`else
    logic              alu_carry_unused;
`endif

    rf_seq_alu #(.DATA_W(DATA_W)) u_alu (
        .op     (op_q),
        .a      (RF_DATAA),
        .b      (RF_DATAB),
        .result (alu_result),
`ifdef RF_SEQ_FLAGS_EN
        .carry  (alu_carry)
`else
        .carry  (alu_carry_unused)
`endif
    );

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Status outputs decode straight from the state register, so RESET clears
    // RF_WRITE/BUSY/DONE immediately rather than at the next edge.
    always_comb begin
        state_nxt = state;
        BUSY      = 1'b1;
        DONE      = 1'b0;
        RF_WRITE  = 1'b0;
        case (state)
            S_IDLE: begin
                BUSY = 1'b0;
                if (START) state_nxt = (OP == OP_LOADI) ? S_WRITE : S_READ;
            end
            S_READ:  state_nxt = S_EXEC;
            S_EXEC:  state_nxt = S_WRITE;
            S_WRITE: begin
                RF_WRITE  = 1'b1;
                state_nxt = S_FIN;
            end
            S_FIN: begin
                DONE      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign wr_data  = (op_q == OP_LOADI) ? imm_q : alu_q;
    // Write port is zeroed outside WRITE so every output reads 0 after reset.
    assign RF_REGW  = RF_WRITE ? rx_q : '0;
    assign RF_DATAW = RF_WRITE ? wr_data : '0;

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            op_q    <= OP_LOADI;
            rx_q    <= '0;
            imm_q   <= '0;
            alu_q   <= '0;
            RF_REGA <= '0;
            RF_REGB <= '0;
            RESULT  <= '0;
        end else begin
            if (state == S_IDLE && START) begin
                op_q    <= OP;
                rx_q    <= RX;
                imm_q   <= IMM;
                RF_REGA <= RX;
                RF_REGB <= RY;
            end
            if (state == S_EXEC) alu_q <= alu_result;
            if (state == S_WRITE) RESULT <= wr_data;
        end
    end

`ifdef RF_SEQ_FLAGS_EN
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            carry_q <= 1'b0;
            CARRY   <= 1'b0;
            ZERO    <= 1'b0;
        end else begin
            if (state == S_EXEC) carry_q <= alu_carry;
            if (state == S_WRITE) begin
                ZERO <= (wr_data == '0);
                // LOADI and MOV leave CARRY untouched.
                if (op_q == OP_ADD || op_q == OP_SUB) CARRY <= carry_q;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rf_sequencer.sv
// tb_rf_sequencer
// Directed bench for rf_sequencer with a behavioural 16x8 register file
// (combinational read, write on rising edge). Flag checks are compiled in
// when RF_SEQ_FLAGS_EN is defined.
module tb_rf_sequencer;
    import rf_seq_pkg::*;

    logic       CLOCK_50 = 1'b0;
    logic       RESET    = 1'b1;
    logic       START    = 1'b0;
    logic [1:0] OP       = 2'b00;
    logic [3:0] RX       = '0;
    logic [3:0] RY       = '0;
    logic [7:0] IMM      = '0;
    logic       BUSY, DONE, RF_WRITE;
    logic [7:0] RESULT, RF_DATAW, RF_DATAA, RF_DATAB;
    logic [3:0] RF_REGA, RF_REGB, RF_REGW;
`ifdef RF_SEQ_FLAGS_EN
    logic       CARRY, ZERO;
`endif

    logic [7:0] rf [16];
    int wr_cnt = 0;
    int n_cmp  = 0;
    int n_bad  = 0;
    int w0;

    rf_sequencer dut (
        .CLOCK_50 (CLOCK_50),
        .RESET    (RESET),
        .START    (START),
        .OP       (OP),
        .RX       (RX),
        .RY       (RY),
        .IMM      (IMM),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .RESULT   (RESULT),
        .RF_REGA  (RF_REGA),
        .RF_REGB  (RF_REGB),
        .RF_REGW  (RF_REGW),
        .RF_DATAW (RF_DATAW),
        .RF_WRITE (RF_WRITE),
        .RF_DATAA (RF_DATAA),
        .RF_DATAB (RF_DATAB)
`ifdef RF_SEQ_FLAGS_EN
        ,
        .CARRY    (CARRY),
        .ZERO     (ZERO)
`endif
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    assign RF_DATAA = rf[RF_REGA];
    assign RF_DATAB = rf[RF_REGB];

    always @(posedge CLOCK_50) begin
        if (RF_WRITE) begin
            rf[RF_REGW] <= RF_DATAW;
            wr_cnt      <= wr_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_flags(input logic c, input logic z);
`ifdef RF_SEQ_FLAGS_EN
        chk("carry", CARRY, c);
        chk("zero", ZERO, z);
`endif
    endtask

    // Issue one command and check the cycle-exact write-back and DONE timing.
    task automatic do_cmd(input logic [1:0] op, input logic [3:0] rx, input logic [3:0] ry,
                          input logic [7:0] imm, input logic [7:0] exp);
        int base;
        base = wr_cnt;
        @(negedge CLOCK_50);
        START = 1'b1; OP = op; RX = rx; RY = ry; IMM = imm;
        @(negedge CLOCK_50);                       // cycle 1
        START = 1'b0;
        chk("busy_c1", BUSY, 1'b1);
        chk("rega", RF_REGA, rx);
        chk("regb", RF_REGB, ry);
        if (op != OP_LOADI) begin
            chk("no_wr_c1", RF_WRITE, 1'b0);
            @(negedge CLOCK_50);                   // cycle 2
            chk("no_wr_c2", RF_WRITE, 1'b0);
            @(negedge CLOCK_50);                   // cycle 3
        end
        chk("wr", RF_WRITE, 1'b1);
        chk("regw", RF_REGW, rx);
        chk("dataw", RF_DATAW, exp);
        chk("done_early", DONE, 1'b0);
        @(negedge CLOCK_50);
        chk("done", DONE, 1'b1);
        chk("result", RESULT, exp);
        chk("one_write", wr_cnt - base, 1);
        chk("rf_content", rf[rx], exp);
        @(negedge CLOCK_50);
        chk("idle_busy", BUSY, 1'b0);
        chk("idle_done", DONE, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge CLOCK_50);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_done", DONE, 1'b0);
        chk("rst_result", RESULT, 8'h00);
        chk("rst_rega", RF_REGA, 4'h0);
        chk("rst_regb", RF_REGB, 4'h0);
        chk("rst_regw", RF_REGW, 4'h0);
        chk("rst_dataw", RF_DATAW, 8'h00);
        chk("rst_write", RF_WRITE, 1'b0);
        chk_flags(1'b0, 1'b0);
        RESET = 1'b0;
        @(negedge CLOCK_50);

        do_cmd(OP_LOADI, 4'd2, 4'd0, 8'h5A, 8'h5A);

        do_cmd(OP_LOADI, 4'd1, 4'd0, 8'hF0, 8'hF0);
        do_cmd(OP_LOADI, 4'd2, 4'd0, 8'h20, 8'h20);
        do_cmd(OP_ADD, 4'd1, 4'd2, 8'h00, 8'h10);
        chk_flags(1'b1, 1'b0);

        do_cmd(OP_LOADI, 4'd3, 4'd0, 8'h05, 8'h05);
        do_cmd(OP_LOADI, 4'd4, 4'd0, 8'h05, 8'h05);
        do_cmd(OP_SUB, 4'd3, 4'd4, 8'h00, 8'h00);
        chk_flags(1'b0, 1'b1);
        do_cmd(OP_LOADI, 4'd3, 4'd0, 8'h03, 8'h03);
        do_cmd(OP_LOADI, 4'd4, 4'd0, 8'h04, 8'h04);
        do_cmd(OP_SUB, 4'd3, 4'd4, 8'h00, 8'hFF);
        chk_flags(1'b1, 1'b0);
        do_cmd(OP_LOADI, 4'd0, 4'd0, 8'h00, 8'h00);
        chk_flags(1'b1, 1'b1);                     // LOADI holds CARRY

        // START while busy: LOADI R7 pulsed during EXEC of ADD R1,R2 must vanish.
        do_cmd(OP_LOADI, 4'd7, 4'd0, 8'h11, 8'h11);
        w0 = wr_cnt;
        @(negedge CLOCK_50);
        START = 1'b1; OP = OP_ADD; RX = 4'd1; RY = 4'd2; IMM = 8'h00;
        @(negedge CLOCK_50);
        START = 1'b0;
        @(negedge CLOCK_50);
        START = 1'b1; OP = OP_LOADI; RX = 4'd7; RY = 4'd7; IMM = 8'hEE;
        @(negedge CLOCK_50);
        START = 1'b0;
        chk("busy_wr", RF_WRITE, 1'b1);
        chk("busy_regw", RF_REGW, 4'd1);
        chk("busy_dataw", RF_DATAW, 8'h30);
        chk("busy_rega", RF_REGA, 4'd1);
        @(negedge CLOCK_50);
        chk("busy_done", DONE, 1'b1);
        repeat (5) @(negedge CLOCK_50);
        chk("busy_writes", wr_cnt - w0, 1);
        chk("busy_r7", rf[7], 8'h11);
        chk("busy_r1", rf[1], 8'h30);
        chk("busy_idle", BUSY, 1'b0);

        // Reset during EXEC of ADD R1,R2.
        w0 = wr_cnt;
        @(negedge CLOCK_50);
        START = 1'b1; OP = OP_ADD; RX = 4'd1; RY = 4'd2;
        @(negedge CLOCK_50);
        START = 1'b0;
        @(negedge CLOCK_50);
        chk("exec_busy", BUSY, 1'b1);
        #3 RESET = 1'b1;
        #1;
        chk("arst_busy", BUSY, 1'b0);
        chk("arst_done", DONE, 1'b0);
        chk("arst_write", RF_WRITE, 1'b0);
        chk("arst_result", RESULT, 8'h00);
        chk("arst_rega", RF_REGA, 4'h0);
        chk("arst_regb", RF_REGB, 4'h0);
        chk_flags(1'b0, 1'b0);
        @(negedge CLOCK_50);
        RESET = 1'b0;
        repeat (4) @(negedge CLOCK_50);
        chk("arst_no_write", wr_cnt - w0, 0);
        chk("arst_r1", rf[1], 8'h30);

        // Reset during WRITE: enable must drop without waiting for an edge.
        w0 = wr_cnt;
        @(negedge CLOCK_50);
        START = 1'b1; OP = OP_ADD; RX = 4'd1; RY = 4'd2;
        @(negedge CLOCK_50);
        START = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        chk("wrst_pre", RF_WRITE, 1'b1);
        #3 RESET = 1'b1;
        #1;
        chk("wrst_write", RF_WRITE, 1'b0);
        chk("wrst_dataw", RF_DATAW, 8'h00);
        @(negedge CLOCK_50);
        RESET = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        chk("wrst_no_write", wr_cnt - w0, 0);
        chk("wrst_r1", rf[1], 8'h30);

        do_cmd(OP_LOADI, 4'd9, 4'd0, 8'h77, 8'h77);

        // Aliased operands.
        do_cmd(OP_LOADI, 4'd6, 4'd0, 8'h81, 8'h81);
        do_cmd(OP_ADD, 4'd6, 4'd6, 8'h00, 8'h02);
        chk_flags(1'b1, 1'b0);
        do_cmd(OP_LOADI, 4'd5, 4'd0, 8'h3C, 8'h3C);
        do_cmd(OP_MOV, 4'd5, 4'd5, 8'h00, 8'h3C);
        chk_flags(1'b1, 1'b0);                     // MOV holds CARRY
        do_cmd(OP_MOV, 4'd8, 4'd5, 8'h00, 8'h3C);
        do_cmd(OP_SUB, 4'd3, 4'd3, 8'h00, 8'h00);
        chk_flags(1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
